// File: rtl/traffic_input_cond_pkg.sv
// Shared types and defaults for the traffic-light input conditioning block.
package traffic_input_cond_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StReq     = 2'b01,
    StWaitRel = 2'b10
  } ped_state_e;

  localparam int unsigned DefDebTicks  = 4;
  localparam int unsigned DefNightHold = 8;

  // Sized for the largest legal DEB_TICKS (15) and NIGHT_HOLD (255).
  localparam int unsigned DebCntW  = 4;
  localparam int unsigned HoldCntW = 8;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer followed by a tick-sampled debouncer for one raw input.
module debounce_cell
  import traffic_input_cond_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DefDebTicks
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level
);

  logic               sync1_q, sync2_q;
  logic               level_q, level_d;
  logic [DebCntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts consecutive ticks that disagree with the stable level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (cnt_q == DebCntW'(DEB_TICKS - 1)) begin
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DebCntW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/traffic_input_cond.sv
// Conditions the run/pause, night and pedestrian inputs for the traffic controller.
module traffic_input_cond
  import traffic_input_cond_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = DefDebTicks,
  parameter int unsigned NIGHT_HOLD = DefNightHold,
  parameter bit          ENABLE_RST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_enable,
  input  logic sw_night,
  input  logic btn_ped,
  input  logic ped_ack,
  output logic enable,
  output logic nightcomes,
  output logic ped_req
);

  localparam logic [HoldCntW-1:0] HoldMax = HoldCntW'(NIGHT_HOLD);

  logic en_db, night_db, ped_db;

  debounce_cell #(.DEB_TICKS(DEB_TICKS)) u_deb_enable (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .raw  (btn_enable),
    .level(en_db)
  );

  debounce_cell #(.DEB_TICKS(DEB_TICKS)) u_deb_night (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .raw  (sw_night),
    .level(night_db)
  );

  debounce_cell #(.DEB_TICKS(DEB_TICKS)) u_deb_ped (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .raw  (btn_ped),
    .level(ped_db)
  );

  logic                en_prev_q, ped_prev_q;
  logic                enable_q, enable_d;
  logic                night_q, night_d;
  logic [HoldCntW-1:0] hold_q, hold_d;
  ped_state_e          state_q, state_d;
  logic                ped_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_prev_q  <= 1'b0;
      ped_prev_q <= 1'b0;
      enable_q   <= ENABLE_RST;
      night_q    <= 1'b0;
      hold_q     <= HoldMax;
      state_q    <= StIdle;
    end else begin
      en_prev_q  <= en_db;
      ped_prev_q <= ped_db;
      enable_q   <= enable_d;
      night_q    <= night_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    enable_d = enable_q ^ (en_db & ~en_prev_q);

    // Hold starts saturated so the first night change after reset is immediate.
    night_d = night_q;
    hold_d  = hold_q;
    if (tick && (hold_q != HoldMax)) begin
      hold_d = hold_q + HoldCntW'(1);
    end
    if ((night_db != night_q) && (hold_q == HoldMax)) begin
      night_d = night_db;
      hold_d  = '0;
    end

    ped_rise = ped_db & ~ped_prev_q;
    state_d  = state_q;
    case (state_q)
      StIdle:    if (ped_rise) state_d = StReq;
      StReq:     if (ped_ack) state_d = StWaitRel;
      StWaitRel: if (!ped_db) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (night_q) begin
      state_d = StIdle;
    end
  end

  assign enable     = enable_q;
  assign nightcomes = night_q;
  assign ped_req    = (state_q == StReq);

endmodule

// File: tb/tb_traffic_input_cond.sv
// Self-checking bench: vector table, directed corner sequences and a random run vs. a model.
module tb_traffic_input_cond;

  localparam int DEB = 4;
  localparam int NH  = 8;
  localparam logic [7:0] NH8 = 8'(NH);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic btn_enable = 1'b0;
  logic sw_night = 1'b0;
  logic btn_ped = 1'b0;
  logic ped_ack = 1'b0;
  logic enable, nightcomes, ped_req;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b1;

  always #5 clk = ~clk;

  traffic_input_cond #(
    .DEB_TICKS (DEB),
    .NIGHT_HOLD(NH),
    .ENABLE_RST(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn_enable(btn_enable),
    .sw_night  (sw_night),
    .btn_ped   (btn_ped),
    .ped_ack   (ped_ack),
    .enable    (enable),
    .nightcomes(nightcomes),
    .ped_req   (ped_req)
  );

  // Reference model: index 0 = enable button, 1 = night switch, 2 = ped button.
  typedef struct packed {
    logic [2:0]      s1;
    logic [2:0]      s2;
    logic [2:0]      lvl;
    logic [2:0][7:0] run;
    logic            prev_en;
    logic            prev_ped;
    logic            en;
    logic            night;
    logic            pending;
    logic            waitrel;
    logic [7:0]      hold;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r      = '0;
    r.en   = 1'b1;
    r.hold = NH8;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic [2:0] raw, logic tk, logic ack);
    model_t n;
    n = c;
    // Pedestrian: one request per fresh press outside night, kept until acknowledged.
    if (c.night) begin
      n.pending = 1'b0;
      n.waitrel = 1'b0;
    end else if (c.pending) begin
      if (ack) begin
        n.pending = 1'b0;
        n.waitrel = 1'b1;
      end
    end else if (c.waitrel) begin
      if (!c.lvl[2]) n.waitrel = 1'b0;
    end else if (c.lvl[2] && !c.prev_ped) begin
      n.pending = 1'b1;
    end
    n.prev_ped = c.lvl[2];
    if (c.lvl[0] && !c.prev_en) n.en = ~c.en;
    n.prev_en = c.lvl[0];
    if ((c.lvl[1] != c.night) && (c.hold == NH8)) begin
      n.night = c.lvl[1];
      n.hold  = 8'd0;
    end else if (tk && (c.hold < NH8)) begin
      n.hold = c.hold + 8'd1;
    end
    for (int i = 0; i < 3; i++) begin
      if (tk) begin
        if (c.s2[i] != c.lvl[i]) begin
          if (c.run[i] == 8'(DEB - 1)) begin
            n.lvl[i] = c.s2[i];
            n.run[i] = 8'd0;
          end else begin
            n.run[i] = c.run[i] + 8'd1;
          end
        end else begin
          n.run[i] = 8'd0;
        end
      end
    end
    n.s1 = raw;
    n.s2 = c.s1;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, {btn_ped, sw_night, btn_enable}, tick, ped_ack);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if ({enable, nightcomes, ped_req} !== {m.en, m.night, m.pending}) begin
        n_fail++;
        $display("FAIL model t=%0t en/night/ped got %b%b%b want %b%b%b", $time,
                 enable, nightcomes, ped_req, m.en, m.night, m.pending);
      end
    end
  end

  task automatic check(input string nm, input logic [2:0] exp);
    n_tests++;
    if ({enable, nightcomes, ped_req} !== exp) begin
      n_fail++;
      $display("FAIL %s: en/night/ped got %b%b%b want %b", nm, enable, nightcomes, ped_req, exp);
    end
  endtask

  // Each tick is 3 idle clocks then one strobe clock; called and returns at a negedge.
  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b0;
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic settle();
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       en_b;
    logic       night_s;
    logic       ped_b;
    logic       ack;
    int         ticks;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // exp = {enable, nightcomes, ped_req}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 3'b100};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 3'b000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 3'b000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b100};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b100};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 3'b110};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b110};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 3'b110};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 3'b100};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 3'b101};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 3'b100};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 3'b100};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b100};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 3'b101};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 4, 3'b110};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 3'b110};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 4, 3'b110};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b100};

    repeat (3) @(negedge clk);
    check("reset values", 3'b100);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      btn_enable = tbl[i].en_b;
      sw_night   = tbl[i].night_s;
      btn_ped    = tbl[i].ped_b;
      ped_ack    = tbl[i].ack;
      do_ticks(tbl[i].ticks);
      settle();
      check($sformatf("table step %0d", i), tbl[i].exp);
    end

    // Chatter on every input, one tick per level, never accepted.
    for (int k = 0; k < 20; k++) begin
      btn_enable = k[0];
      sw_night   = k[0];
      btn_ped    = k[0];
      do_ticks(1);
    end
    btn_enable = 1'b0;
    sw_night   = 1'b0;
    btn_ped    = 1'b0;
    do_ticks(2);
    settle();
    check("chatter", 3'b100);

    // Night rises in the same cycle that ped_ack arrives.
    btn_ped = 1'b1;
    do_ticks(4);
    settle();
    check("ped pending before night", 3'b101);
    sw_night = 1'b1;
    do_ticks(4);
    ped_ack = 1'b1;
    @(negedge clk);
    check("night with ack", 3'b110);
    @(negedge clk);
    btn_ped = 1'b0;
    do_ticks(4);
    btn_ped = 1'b1;
    do_ticks(4);
    settle();
    check("press during night", 3'b110);
    ped_ack  = 1'b0;
    btn_ped  = 1'b0;
    sw_night = 1'b0;
    do_ticks(10);
    settle();
    check("night cleared", 3'b100);

    // Reset in the middle of a request with debounces in progress.
    btn_enable = 1'b1;
    btn_ped    = 1'b1;
    do_ticks(4);
    settle();
    check("pre-reset state", 3'b001);
    btn_enable = 1'b0;
    sw_night   = 1'b1;
    do_ticks(2);
    #2 reset = 1'b0;
    #1 check("async reset", 3'b100);
    btn_ped  = 1'b0;
    sw_night = 1'b0;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    sw_night = 1'b1;
    do_ticks(4);
    settle();
    check("first night after reset", 3'b110);
    sw_night = 1'b0;
    do_ticks(12);
    settle();
    check("no stale request", 3'b100);

    // Random run, checked every clock by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tick = ($urandom_range(2) == 0);
      if ($urandom_range(39) == 0) btn_enable = ~btn_enable;
      if ($urandom_range(39) == 0) sw_night = ~sw_night;
      if ($urandom_range(39) == 0) btn_ped = ~btn_ped;
      ped_ack = ($urandom_range(7) == 0);
      if (!reset) begin
        #2 reset = 1'b1;
      end else if ($urandom_range(999) == 0) begin
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
